// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, op codes, FSM state encoding and a one-bit
// alignment shift helper for the floating-point operand aligner.
//
// Contents:
//   EXP_W / FRAC_W / MAN_W  IEEE-754 single field widths; MAN_W is
//                           {hidden, fraction, guard, round, sticky}
//   EXP_MAX                 exponent value marking Inf/NaN
//   SHIFT_MAX / CNT_W       alignment shift saturation and counter width
//   OP_*                    ALU control codes carried alongside the operands
//   state_e                 aligner FSM states
//   shr1()                  single-step right shift with optional sticky OR
package fp_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned MAN_W     = 27;
  localparam int unsigned SHIFT_MAX = 27;
  localparam int unsigned CNT_W     = 5;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Shift right by one; with sticky_en the bit leaving bit 0 is folded back
  // into bit 0 so no set bit is ever lost from the sticky position.
  function automatic logic [MAN_W-1:0] shr1(input logic [MAN_W-1:0] m,
                                            input logic             sticky_en);
    logic [MAN_W-1:0] r;
    r    = m >> 1;
    r[0] = r[0] | (sticky_en & m[0]);
    return r;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: combinational split of an IEEE-754 single word into sign,
// raw exponent, fraction and an aligner-ready mantissa, with Inf/NaN and
// denormal/zero flags.
//
// Ports:
//   word       in   32-bit IEEE-754 single
//   sign_c     out  sign bit
//   exp_c      out  raw biased exponent
//   frac_c     out  23-bit fraction
//   man_c      out  {hidden, fraction, 3'b000}; hidden=0 for exponent 0
//   special_c  out  exponent is all ones (Inf/NaN)
//   denorm_c   out  exponent is zero (denormal or zero)
module fp_unpack
  import fp_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic              sign_c,
  output logic [EXP_W-1:0]  exp_c,
  output logic [FRAC_W-1:0] frac_c,
  output logic [MAN_W-1:0]  man_c,
  output logic              special_c,
  output logic              denorm_c
);

  // Field split and hidden-bit insertion.
  always_comb begin
    sign_c    = word[WORD_W-1];
    exp_c     = word[WORD_W-2 -: EXP_W];
    frac_c    = word[FRAC_W-1:0];
    denorm_c  = (exp_c == '0);
    special_c = (exp_c == EXP_MAX);
    man_c     = {~denorm_c, frac_c, 3'b000};
  end

endmodule

// File: rtl/fp_align.sv
// fp_align: floating-point operand aligner. Accepts an IEEE-754 single
// operand pair plus an ALU op code, orders the operands by magnitude and
// right-shifts the smaller mantissa one bit per cycle until both share the
// larger exponent. The aligned pair is held until the downstream mantissa
// ALU consumes it.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (ready only when idle)
//   a, b                 IEEE-754 single operands
//   op                   ALU control code (op==01 inverts the sign of B)
//   out_valid/out_ready  result handshake
//   exp_out              common (larger) effective biased exponent
//   sign_big/sign_small  effective signs of larger/smaller magnitude operand
//   man_big/man_small    {hidden, fraction, guard, round, sticky}
//   swapped              B had the larger magnitude
//   op_out               captured op code
//   special              either operand is Inf/NaN; mantissas pass unshifted
//
// Build option: FP_ALIGN_STICKY_EN -- when defined, bits shifted out of
// man_small[0] are ORed back into it; otherwise the shift is plain logical.
module fp_align
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [1:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_out,
  output logic              sign_big,
  output logic              sign_small,
  output logic [MAN_W-1:0]  man_big,
  output logic [MAN_W-1:0]  man_small,
  output logic              swapped,
  output logic [1:0]        op_out,
  output logic              special
);

`ifdef FP_ALIGN_STICKY_EN
  localparam logic STICKY_EN = 1'b1;
`else
  localparam logic STICKY_EN = 1'b0;
`endif

  // Operand unpack.
  logic              sign_a_c,    sign_b_c;
  logic [EXP_W-1:0]  exp_a_c,     exp_b_c;
  logic [FRAC_W-1:0] frac_a_c,    frac_b_c;
  logic [MAN_W-1:0]  man_a_c,     man_b_c;
  logic              special_a_c, special_b_c;
  logic              denorm_a_c,  denorm_b_c;

  fp_unpack u_unpack_a (
    .word      (a),
    .sign_c    (sign_a_c),
    .exp_c     (exp_a_c),
    .frac_c    (frac_a_c),
    .man_c     (man_a_c),
    .special_c (special_a_c),
    .denorm_c  (denorm_a_c)
  );

  fp_unpack u_unpack_b (
    .word      (b),
    .sign_c    (sign_b_c),
    .exp_c     (exp_b_c),
    .frac_c    (frac_b_c),
    .man_c     (man_b_c),
    .special_c (special_b_c),
    .denorm_c  (denorm_b_c)
  );

  // State and registered outputs.
  state_e            state_q,      state_d;
  logic              in_ready_q,   in_ready_d;
  logic              out_valid_q,  out_valid_d;
  logic [EXP_W-1:0]  exp_out_q,    exp_out_d;
  logic              sign_big_q,   sign_big_d;
  logic              sign_small_q, sign_small_d;
  logic [MAN_W-1:0]  man_big_q,    man_big_d;
  logic [MAN_W-1:0]  man_small_q,  man_small_d;
  logic              swapped_q,    swapped_d;
  logic [1:0]        op_out_q,     op_out_d;
  logic              special_q,    special_d;
  logic [CNT_W-1:0]  count_q,      count_d;

  // Magnitude ordering and shift distance of the incoming pair.
  logic              sign_b_eff_c;
  logic              b_bigger_c;
  logic [EXP_W-1:0]  exp_a_eff_c, exp_b_eff_c;
  logic [EXP_W-1:0]  exp_big_c,   exp_small_c;
  logic [EXP_W-1:0]  diff_c;
  logic [CNT_W-1:0]  shift_c;
  logic              special_c;

  always_comb begin
    sign_b_eff_c = sign_b_c ^ (op == OP_SUB);
    // Denormals and zeros are aligned as if their exponent were 1.
    exp_a_eff_c  = denorm_a_c ? EXP_W'(1) : exp_a_c;
    exp_b_eff_c  = denorm_b_c ? EXP_W'(1) : exp_b_c;
    // Raw {exp,frac} ordering matches effective magnitude; ties keep A big.
    b_bigger_c   = {exp_b_c, frac_b_c} > {exp_a_c, frac_a_c};
    exp_big_c    = b_bigger_c ? exp_b_eff_c : exp_a_eff_c;
    exp_small_c  = b_bigger_c ? exp_a_eff_c : exp_b_eff_c;
    diff_c       = exp_big_c - exp_small_c;
    special_c    = special_a_c | special_b_c;
    if (special_c) begin
      shift_c = '0;
    end else if (diff_c > EXP_W'(SHIFT_MAX)) begin
      shift_c = CNT_W'(SHIFT_MAX);
    end else begin
      shift_c = CNT_W'(diff_c);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    exp_out_d    = exp_out_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    man_big_d    = man_big_q;
    man_small_d  = man_small_q;
    swapped_d    = swapped_q;
    op_out_d     = op_out_q;
    special_d    = special_q;
    count_d      = count_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          exp_out_d    = exp_big_c;
          swapped_d    = b_bigger_c;
          sign_big_d   = b_bigger_c ? sign_b_eff_c : sign_a_c;
          sign_small_d = b_bigger_c ? sign_a_c     : sign_b_eff_c;
          man_big_d    = b_bigger_c ? man_b_c      : man_a_c;
          man_small_d  = b_bigger_c ? man_a_c      : man_b_c;
          op_out_d     = op;
          special_d    = special_c;
          count_d      = shift_c;
          state_d      = (shift_c == '0) ? ST_DONE : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        man_small_d = shr1(man_small_q, STICKY_EN);
        count_d     = (count_q == '0) ? count_q : count_q - CNT_W'(1);
        if (count_q <= CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // out_valid trails DONE entry by one cycle; ready returns after idle.
    out_valid_d = (state_q == ST_DONE) && !(out_valid_q && out_ready);
    in_ready_d  = (state_d == ST_IDLE);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      exp_out_q    <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      man_big_q    <= '0;
      man_small_q  <= '0;
      swapped_q    <= 1'b0;
      op_out_q     <= '0;
      special_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      exp_out_q    <= exp_out_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      man_big_q    <= man_big_d;
      man_small_q  <= man_small_d;
      swapped_q    <= swapped_d;
      op_out_q     <= op_out_d;
      special_q    <= special_d;
      count_q      <= count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign exp_out    = exp_out_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign man_big    = man_big_q;
  assign man_small  = man_small_q;
  assign swapped    = swapped_q;
  assign op_out     = op_out_q;
  assign special    = special_q;

endmodule

// File: tb/tb_fp_align.sv
// tb_fp_align: table-driven and randomised checks of fp_align through a
// scoreboard queue, plus hand-written backpressure and mid-align reset
// sequences. Honours FP_ALIGN_STICKY_EN for the expected shifted mantissa.
module tb_fp_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic        sign_big;
  logic        sign_small;
  logic [26:0] man_big;
  logic [26:0] man_small;
  logic        swapped;
  logic [1:0]  op_out;
  logic        special;

  fp_align dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exp_out    (exp_out),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .man_big    (man_big),
    .man_small  (man_small),
    .swapped    (swapped),
    .op_out     (op_out),
    .special    (special)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [7:0]  e_exp;
    logic        e_sb;
    logic        e_ss;
    logic        e_sw;
    logic        e_sp;
    logic [26:0] e_mb;
    logic [26:0] e_ms;
    int          lat;
    int          acc;
  } vec_t;

`ifdef FP_ALIGN_STICKY_EN
  localparam logic [26:0] MS_D24  = 27'h5;
  localparam logic [26:0] MS_SAT  = 27'h1;
  localparam logic        STICKY  = 1'b1;
`else
  localparam logic [26:0] MS_D24  = 27'h4;
  localparam logic [26:0] MS_SAT  = 27'h0;
  localparam logic        STICKY  = 1'b0;
`endif

  int   n_err = 0;
  int   n_chk = 0;
  vec_t q[$];
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop,
                              input logic [7:0] ex, input logic sb, input logic ss, input logic sw,
                              input logic sp, input logic [26:0] mb, input logic [26:0] ms, input int lat);
    vec_t v;
    v.a = va; v.b = vb; v.op = vop; v.e_exp = ex; v.e_sb = sb; v.e_ss = ss;
    v.e_sw = sw; v.e_sp = sp; v.e_mb = mb; v.e_ms = ms; v.lat = lat; v.acc = 0;
    return v;
  endfunction

  // Reference alignment: one wide shift plus a mask for the lost bits.
  function automatic vec_t model(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop);
    vec_t v;
    logic [7:0]  ea, eb, eea, eeb, d;
    logic [26:0] ma, mb, msm;
    logic        sbe, swp, sp;
    int          sh;
    logic [63:0] s64, lost;
    ea  = va[30:23];
    eb  = vb[30:23];
    eea = (ea == 8'd0) ? 8'd1 : ea;
    eeb = (eb == 8'd0) ? 8'd1 : eb;
    ma  = {(ea != 8'd0), va[22:0], 3'b000};
    mb  = {(eb != 8'd0), vb[22:0], 3'b000};
    sbe = vb[31] ^ (vop == 2'b01);
    swp = {eb, vb[22:0]} > {ea, va[22:0]};
    sp  = (ea == 8'hFF) || (eb == 8'hFF);
    d   = swp ? (eeb - eea) : (eea - eeb);
    sh  = sp ? 0 : ((d > 8'd27) ? 27 : int'(d));
    s64 = 64'(swp ? ma : mb);
    lost = s64 & ((64'd1 << sh) - 64'd1);
    msm = 27'(s64 >> sh);
    if (STICKY && lost != 64'd0) msm[0] = 1'b1;
    v = mk(va, vb, vop, swp ? eeb : eea, swp ? sbe : va[31], swp ? va[31] : sbe,
           swp, sp, swp ? mb : ma, msm, 1 + sh);
    return v;
  endfunction

  // Offer one pair; the expectation is queued on the cycle it is accepted.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    @(posedge clk); #1;
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    v.acc = cyc + 1;
    q.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Scoreboard monitor: latency on the rising out_valid, fields on handshake.
  initial begin : monitor
    bit   seen;
    vec_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          end
          if (out_ready) begin
            e = q.pop_front();
            seen = 1'b0;
            chk("exp_out",    32'(exp_out),    32'(e.e_exp));
            chk("sign_big",   32'(sign_big),   32'(e.e_sb));
            chk("sign_small", 32'(sign_small), 32'(e.e_ss));
            chk("swapped",    32'(swapped),    32'(e.e_sw));
            chk("special",    32'(special),    32'(e.e_sp));
            chk("man_big",    32'(man_big),    32'(e.e_mb));
            chk("man_small",  32'(man_small),  32'(e.e_ms));
            chk("op_out",     32'(op_out),     32'(e.op));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t v;
    int   bad;
    logic [7:0] ea, eb;

    //         a             b             op     exp    sb    ss    sw    sp    man_big       man_small     lat
    tbl[0] = mk(32'h3F800000, 32'h3F800000, 2'b00, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 27'h4000000, 27'h4000000, 1);
    tbl[1] = mk(32'h40000000, 32'h3F800000, 2'b00, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 27'h4000000, 27'h2000000, 2);
    tbl[2] = mk(32'h3F800000, 32'h40000000, 2'b01, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 27'h4000000, 27'h2000000, 2);
    tbl[3] = mk(32'h4B800000, 32'h3F800001, 2'b00, 8'h97, 1'b0, 1'b0, 1'b0, 1'b0, 27'h4000000, MS_D24,      25);
    tbl[4] = mk(32'h00000001, 32'h00800000, 2'b10, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 27'h4000000, 27'h0000008, 1);
    tbl[5] = mk(32'h7E800000, 32'h3F800000, 2'b00, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 27'h4000000, MS_SAT,      28);
    tbl[6] = mk(32'hC0400000, 32'h40400000, 2'b01, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 27'h6000000, 27'h6000000, 1);
    tbl[7] = mk(32'h4C800000, 32'h3F800000, 2'b11, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 27'h4000000, 27'h0000001, 27);
    tbl[8] = mk(32'h3F800000, 32'h7FC00000, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 27'h6000000, 27'h4000000, 1);
    tbl[9] = mk(32'h00000000, 32'h00000000, 2'b00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 27'h0000000, 27'h0000000, 1);

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_exp_out",   32'(exp_out),   32'd0);
    chk("rst_man_big",   32'(man_big),   32'd0);
    chk("rst_man_small", 32'(man_small), 32'd0);
    chk("rst_flags",     32'({sign_big, sign_small, swapped, special, op_out}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      send(tbl[i]);
    end
    wait_idle();

    // Inf operand held under backpressure.
    out_ready = 1'b0;
    send(mk(32'h7F800000, 32'h3F800000, 2'b00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1,
            27'h4000000, 27'h4000000, 1));
    for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready",  32'(in_ready),  32'd0);
      chk("hold_data",      32'({exp_out, special, swapped}), 32'({8'hFF, 1'b1, 1'b0}));
      chk("hold_man_small", 32'(man_small), 32'h4000000);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("hs_cycle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("after_hs_in_ready",  32'(in_ready),  32'd1);
    chk("after_hs_out_valid", 32'(out_valid), 32'd0);
    wait_idle();

    // Reset in the middle of a diff=20 alignment discards the operation.
    send(mk(32'h49800000, 32'h3F800000, 2'b00, 8'h93, 1'b0, 1'b0, 1'b0, 1'b0,
            27'h4000000, 27'h0000040, 21));
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_man_small", 32'(man_small), 32'd0);
    @(negedge clk);
    chk("midrst_hold_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad++;
    end
    chk("post_rst_idle", 32'(bad), 32'd0);
    send(tbl[1]);
    send(tbl[3]);
    wait_idle();

    // Randomised pairs against the reference model.
    for (int i = 0; i < 24; i++) begin
      ea = 8'($urandom_range(0, 200));
      eb = (i % 3 == 0) ? ea : 8'($urandom_range(0, 200));
      if (i == 7) eb = 8'hFF;
      v = model({1'($urandom), ea, 23'($urandom)}, {1'($urandom), eb, 23'($urandom)},
                2'($urandom));
      send(v);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_align.md
FP_ALIGN -- requirements
Module: fp_align

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  operand pair a/b/op offered.
REQ-004 in_ready  output  1  block accepts a new pair this cycle.
REQ-005 a  input  32  IEEE-754 single operand A.
REQ-006 b  input  32  IEEE-754 single operand B.
REQ-007 op  input  2  ALU control code: 00 add, 01 sub, 10 and, 11 or; op[0] also serves as the adder carry-in/invert select downstream.
REQ-008 out_valid  output  1  aligned result available.
REQ-009 out_ready  input  1  downstream mantissa ALU consumes the result.
REQ-010 exp_out  output  8  common (larger) biased exponent.
REQ-011 sign_big, sign_small  output  1 each  effective signs of the larger and smaller magnitude operands.
REQ-012 man_big, man_small  output  27 each  {hidden, 23 fraction, guard, round, sticky}.
REQ-013 swapped  output  1  B had the larger magnitude.
REQ-014 op_out  output  2  captured op, passed to the 1-bit ALU slice array.
REQ-015 special  output  1  either operand has exponent 255 (Inf/NaN).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ALIGN, DONE; in_ready=1 only in IDLE; in_valid is ignored outside IDLE.
REQ-017 On in_valid&in_ready, the block SHALL capture: hidden bit=1 if exp!=0, else 0 with effective exp=1; mantissa placed as {hidden,frac,3'b000}; B sign inverted when op==01.
REQ-018 The larger magnitude SHALL be selected by comparing {exp,frac}; ties keep A as big (swapped=0).
REQ-019 diff = exp_big - exp_small; the shift count SHALL saturate at 27.
REQ-020 Next state after capture: DONE if special=1 or diff==0; else ALIGN.
REQ-021 In ALIGN, man_small SHALL shift right one bit per cycle and the count SHALL decrement; go to DONE on the cycle the count reaches 0.
REQ-022 Latency: out_valid SHALL rise exactly 1+min(diff,27) cycles after the accept edge (1 for special).
REQ-023 In DONE, out_valid=1 and all outputs SHALL stay stable until out_valid&out_ready; the state then moves to IDLE, and in_ready rises the next cycle (no same-cycle bypass).
REQ-024 When special=1, the mantissas SHALL pass unshifted.

Reset
REQ-025 rst SHALL force IDLE immediately; out_valid=0, in_ready=1, and all data outputs and the count SHALL be 0.
REQ-026 rst asserted in ALIGN or DONE SHALL discard the operation; no out_valid follows.

Configuration
REQ-027 Macro FP_ALIGN_STICKY_EN: when defined, every bit shifted out of man_small[0] SHALL be ORed into man_small[0] (sticky).
REQ-028 When FP_ALIGN_STICKY_EN is undefined, the shift SHALL be plain logical; timing and interface are unchanged.

Structure
REQ-029 Shared package fp_pkg SHALL hold EXP_W=8, FRAC_W=23, MAN_W=27, EXP_MAX=255, the op code constants and the FSM state enum.
REQ-030 A single sub-module fp_unpack SHALL split a word into sign/exp/mantissa and flag special/denormal.

Verification
REQ-031 a=0x3F800000, b=0x3F800000, op=00 -> out_valid 1 cycle after accept, exp_out=0x7F, man_big=man_small=0x4000000, swapped=0.
REQ-032 a=0x40000000, b=0x3F800000, op=00 -> out_valid 2 cycles after accept, exp_out=0x80, man_small=0x2000000.
REQ-033 a=0x3F800000, b=0x40000000, op=01 -> swapped=1, sign_big=1, sign_small=0, exp_out=0x80.
REQ-034 a=0x4B800000, b=0x3F800001 (diff=24) -> latency 25; man_small=0x5 with FP_ALIGN_STICKY_EN, 0x4 without.
REQ-035 a=0x7F800000, any b -> special=1, out_valid after 1 cycle; then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout, in_ready=1 the cycle after the handshake.
REQ-036 diff=20, rst pulsed at cycle 10 of ALIGN -> out_valid never asserts, in_ready=1 during and after reset, and the next operand pair is processed normally.
